// File: rtl/circuit4_resp_checker_pkg.sv
// Shared types and the reference function for the circuit4 response checker.
// The reference response is the number of ones in the 4-bit input vector.
package circuit4_resp_checker_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return 3'(v[3]) + 3'(v[2]) + 3'(v[1]) + 3'(v[0]);
    endfunction

endpackage

// File: rtl/circuit4_resp_checker_if.sv
// Stimulus/response bundle between the circuit4 test driver (master) and the checker (slave).
interface circuit4_resp_checker_if #(
    parameter int CNT_W = 5
);
    logic             start;
    logic             vec_valid;
    logic             a, b, c, d;
    logic             y2, y1, y0;
    logic             busy;
    logic             done;
    logic             pass;
    logic             timeout;
    logic [CNT_W-1:0] vec_count;
    logic [CNT_W-1:0] err_count;
    logic [3:0]       first_fail_vec;
    logic [2:0]       first_fail_resp;

    modport master (
        output start, vec_valid, a, b, c, d, y2, y1, y0,
        input  busy, done, pass, timeout, vec_count, err_count,
               first_fail_vec, first_fail_resp
    );

    modport slave (
        input  start, vec_valid, a, b, c, d, y2, y1, y0,
        output busy, done, pass, timeout, vec_count, err_count,
               first_fail_vec, first_fail_resp
    );
endinterface

// File: rtl/circuit4_resp_checker_settle_timer.sv
// Loadable down-counter that times how long a vector has been stable.
// A load wins over a decrement; the count stops at zero.
module circuit4_resp_checker_settle_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/circuit4_resp_checker.sv
// Response checker for circuit4: latches each applied vector, waits for it to settle,
// samples {y2,y1,y0} against popcount and keeps counts plus the first failing vector.
module circuit4_resp_checker
    import circuit4_resp_checker_pkg::*;
#(
    parameter int NUM_VECS    = 16,
    parameter int SETTLE_CYC  = 2,
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 5
) (
    input logic clk,
    input logic rst,
    circuit4_resp_checker_if.slave bus
);
    localparam int SET_W  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int WAIT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [SET_W-1:0]  SETTLE_RELOAD = SET_W'(SETTLE_CYC - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST     = WAIT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0]  LAST_VEC_CNT  = CNT_W'(NUM_VECS - 1);

    state_t            state_q, state_d;
    logic [3:0]        vec_q, vec_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  vec_count_q, vec_count_d;
    logic [CNT_W-1:0]  err_count_q, err_count_d;
    logic [3:0]        ff_vec_q, ff_vec_d;
    logic [2:0]        ff_resp_q, ff_resp_d;
    logic              timeout_q, timeout_d;

    logic       set_load;
    logic       set_dec;
    logic       set_zero;
    logic [3:0] vec_in;
    logic [2:0] resp_in;

    assign vec_in  = {bus.a, bus.b, bus.c, bus.d};
    assign resp_in = {bus.y2, bus.y1, bus.y0};

    circuit4_resp_checker_settle_timer #(
        .W (SET_W)
    ) u_settle (
        .clk        (clk),
        .rst        (rst),
        .load_i     (set_load),
        .load_val_i (SETTLE_RELOAD),
        .dec_i      (set_dec),
        .zero_o     (set_zero)
    );

    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        wait_cnt_d  = wait_cnt_q;
        vec_count_d = vec_count_q;
        err_count_d = err_count_q;
        ff_vec_d    = ff_vec_q;
        ff_resp_d   = ff_resp_q;
        timeout_d   = timeout_q;
        set_load    = 1'b0;
        set_dec     = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d     = WAIT;
                    wait_cnt_d  = '0;
                    vec_count_d = '0;
                    err_count_d = '0;
                    ff_vec_d    = '0;
                    ff_resp_d   = '0;
                    timeout_d   = 1'b0;
                end
            end
            WAIT: begin
                if (bus.vec_valid) begin
                    state_d  = SETTLE;
                    vec_d    = vec_in;
                    set_load = 1'b1;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            SETTLE: begin
                // A changed input restarts the settle window on the new vector.
                if (vec_in != vec_q) begin
                    vec_d    = vec_in;
                    set_load = 1'b1;
                end else if (set_zero) begin
                    state_d = SAMPLE;
                end else begin
                    set_dec = 1'b1;
                end
            end
            SAMPLE: begin
                if (resp_in != popcount4(vec_q)) begin
                    if (err_count_q == '0) begin
                        ff_vec_d  = vec_q;
                        ff_resp_d = resp_in;
                    end
                    if (err_count_q != '1) begin
                        err_count_d = err_count_q + 1'b1;
                    end
                end
                vec_count_d = vec_count_q + 1'b1;
                if (vec_count_q == LAST_VEC_CNT) begin
                    state_d = DONE;
                end else begin
                    state_d    = WAIT;
                    wait_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            vec_q       <= '0;
            wait_cnt_q  <= '0;
            vec_count_q <= '0;
            err_count_q <= '0;
            ff_vec_q    <= '0;
            ff_resp_q   <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            wait_cnt_q  <= wait_cnt_d;
            vec_count_q <= vec_count_d;
            err_count_q <= err_count_d;
            ff_vec_q    <= ff_vec_d;
            ff_resp_q   <= ff_resp_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.busy            = (state_q == WAIT) || (state_q == SETTLE) || (state_q == SAMPLE);
    assign bus.done            = (state_q == DONE);
    assign bus.pass            = (state_q == DONE) && (err_count_q == '0) && !timeout_q;
    assign bus.timeout         = timeout_q;
    assign bus.vec_count       = vec_count_q;
    assign bus.err_count       = err_count_q;
    assign bus.first_fail_vec  = ff_vec_q;
    assign bus.first_fail_resp = ff_resp_q;
endmodule
